rr_arb4: RTL

//   Round-robin arbiter sharing one 4:1 mux (mx4) among 4 requesters.

---
 rtl/rr_arb4_pkg.sv | 16 +
 rtl/rr_pick4.sv | 27 ++
 rtl/rr_arb4.sv | 83 ++++++++
 3 files changed

// File: rtl/rr_arb4_pkg.sv
// rtl/rr_arb4_pkg.sv - shared constants and helpers for the 4-way round-robin arbiter
package rr_arb4_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority pick of the first requester at or after ptr
module rr_pick4
    import rr_arb4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               hit,
    output logic [1:0]         idx
);

    logic [1:0] cand;

    // Scan from the far end back toward ptr so the nearest requester is written last.
    always_comb begin
        hit  = 1'b0;
        idx  = 2'd0;
        cand = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - round-robin arbiter granting one 4:1 mux to four requesters with a hold limit
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HCW      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         sel,
    output logic               busy,
    output logic               forced
);

    logic [0:0]     state;
    logic [1:0]     ptr;
    logic [HCW-1:0] hold_cnt;

    logic       owner_req;
    logic       limit;
    logic       release_now;
    logic [1:0] pick_ptr;
    logic       hit;
    logic [1:0] idx;

    // sel always names the current owner while a grant is active.
    assign owner_req   = req[sel];
    assign limit       = (hold_cnt == HCW'(MAX_HOLD - 1));
    assign release_now = (state == ST_GRANT) && (!owner_req || limit);
    // On a release edge the rotated pointer must already steer this cycle's pick.
    assign pick_ptr    = (state == ST_GRANT) ? sel + 2'd1 : ptr;

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .hit (hit),
        .idx (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= 2'd0;
            forced   <= 1'b0;
        end else begin
            forced <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state    <= ST_GRANT;
                        grant    <= onehot4(idx);
                        sel      <= idx;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    if (release_now) begin
                        ptr      <= sel + 2'd1;
                        forced   <= limit && owner_req;
                        hold_cnt <= '0;
                        if (hit) begin
                            grant <= onehot4(idx);
                            sel   <= idx;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = |grant;

endmodule
